maze_timer_ctrl: RTL and testbench

Shared timebase controller for the maze game. One free-running prescaler produces a base tick, and four independently programmable channels schedule off it: player-move repeat, enemy step, blink, and countdown. Each channel emits single-cycle `tick` enables rather than derived clocks, so all downstream logic stays on `clk`. Each channel also keeps a pending-event flag that the consumer acknowledges.

---
 rtl/maze_timer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_maze_timer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/maze_timer_ctrl.sv
// maze_timer_ctrl
// Shared timebase for the maze game. A free-running prescaler produces a
// one-cycle base tick every BASE_DIV clocks. Four programmable channels count
// base ticks and emit single-cycle tick enables, plus a sticky pending flag
// that the consumer acknowledges.
//
// Build option: define TIMER_OVERRUN_EN to build the sticky per-channel
// overrun detector. Without it the overrun port is tied to 4'b0000.
module maze_timer_ctrl #(
    parameter int BASE_DIV = 100_000,
    parameter int PW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_ch,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_oneshot,
    input  logic [3:0]    ch_stop,
    input  logic [3:0]    evt_ack,
    output logic          base_tick,
    output logic [3:0]    tick,
    output logic [3:0]    evt_pending,
    output logic [3:0]    running,
    output logic [3:0]    overrun
);

    localparam int             PCW       = $clog2(BASE_DIV);
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(BASE_DIV - 1);

    logic [PCW-1:0] pcnt_r;
    logic           base_tick_r;

    logic [PW-1:0]  reload_r [4];
    logic [PW-1:0]  reload_s [4];
    logic [PW-1:0]  cnt_r    [4];
    logic [PW-1:0]  cnt_s    [4];
    logic [3:0]     oneshot_r;
    logic [3:0]     oneshot_s;
    logic [3:0]     running_r;
    logic [3:0]     running_s;
    logic [3:0]     pending_r;
    logic [3:0]     pending_s;
    logic [3:0]     tick_r;
    logic [3:0]     expiry_s;
    logic [3:0]     cfg_hit_s;

    // Prescaler: count 0..BASE_DIV-1 and register the wrap as base_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r      <= '0;
            base_tick_r <= 1'b0;
        end else begin
            base_tick_r <= (pcnt_r == PCNT_LAST);
            if (pcnt_r == PCNT_LAST) begin
                pcnt_r <= '0;
            end else begin
                pcnt_r <= pcnt_r + PCW'(1);
            end
        end
    end

    // Per-channel next state; config write beats stop, stop beats countdown.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            reload_s[i]  = reload_r[i];
            cnt_s[i]     = cnt_r[i];
            oneshot_s[i] = oneshot_r[i];
            running_s[i] = running_r[i];
            expiry_s[i]  = 1'b0;
            cfg_hit_s[i] = cfg_we && (cfg_ch == 2'(i));

            if (cfg_hit_s[i]) begin
                // A write in a base_tick cycle loads P and skips that decrement.
                reload_s[i]  = cfg_period;
                cnt_s[i]     = cfg_period;
                oneshot_s[i] = cfg_oneshot;
                running_s[i] = (cfg_period != '0);
            end else if (ch_stop[i]) begin
                // Stop freezes the count; only a new write restarts it.
                running_s[i] = 1'b0;
            end else if (base_tick_r && running_r[i]) begin
                if (cnt_r[i] > PW'(1)) begin
                    cnt_s[i] = cnt_r[i] - PW'(1);
                end else begin
                    expiry_s[i] = 1'b1;
                    if (oneshot_r[i]) begin
                        running_s[i] = 1'b0;
                        cnt_s[i]     = '0;
                    end else begin
                        cnt_s[i]     = reload_r[i];
                    end
                end
            end else begin
                cnt_s[i] = cnt_r[i];
            end

            // Expiry wins over a same-cycle acknowledge.
            if (expiry_s[i]) begin
                pending_s[i] = 1'b1;
            end else if (evt_ack[i]) begin
                pending_s[i] = 1'b0;
            end else begin
                pending_s[i] = pending_r[i];
            end
        end
    end

    // Channel state registers; tick is the registered expiry strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                reload_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
            oneshot_r <= 4'b0000;
            running_r <= 4'b0000;
            pending_r <= 4'b0000;
            tick_r    <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                reload_r[i] <= reload_s[i];
                cnt_r[i]    <= cnt_s[i];
            end
            oneshot_r <= oneshot_s;
            running_r <= running_s;
            pending_r <= pending_s;
            tick_r    <= expiry_s;
        end
    end

`ifdef TIMER_OVERRUN_EN
    logic [3:0] overrun_r;
    logic [3:0] overrun_s;

    // Overrun: expiry while the previous event is still unacknowledged.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (cfg_hit_s[i]) begin
                overrun_s[i] = 1'b0;
            end else if (expiry_s[i] && pending_r[i] && !evt_ack[i]) begin
                overrun_s[i] = 1'b1;
            end else begin
                overrun_s[i] = overrun_r[i];
            end
        end
    end

    // Sticky overrun register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 4'b0000;
        end else begin
            overrun_r <= overrun_s;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 4'b0000;
`endif

    assign base_tick   = base_tick_r;
    assign tick        = tick_r;
    assign evt_pending = pending_r;
    assign running     = running_r;

endmodule

// File: tb/tb_maze_timer_ctrl.sv
// Self-checking bench for maze_timer_ctrl with BASE_DIV=4, PW=16.
// The reference model tracks base-tick ordinals: a channel written after
// base tick number S expires on every base tick B with (B - S) % P == 0.
module tb_maze_timer_ctrl;

    localparam int BD = 4;
    localparam int PW = 16;
`ifdef TIMER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          cfg_we      = 1'b0;
    logic [1:0]    cfg_ch      = 2'd0;
    logic [PW-1:0] cfg_period  = 16'd0;
    logic          cfg_oneshot = 1'b0;
    logic [3:0]    ch_stop     = 4'b0000;
    logic [3:0]    evt_ack     = 4'b0000;
    logic          base_tick;
    logic [3:0]    tick;
    logic [3:0]    evt_pending;
    logic [3:0]    running;
    logic [3:0]    overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maze_timer_ctrl #(.BASE_DIV(BD), .PW(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .ch_stop     (ch_stop),
        .evt_ack     (evt_ack),
        .base_tick   (base_tick),
        .tick        (tick),
        .evt_pending (evt_pending),
        .running     (running),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle number: edge n after reset release starts cycle n.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model state
    int   cyc_m;
    int   bt_cnt;
    int   start_bt [4];
    int   per_m    [4];
    bit   os_m     [4];
    bit   act_m    [4];
    logic       exp_bt;
    logic [3:0] exp_tick, exp_pend, exp_run, exp_ovr;
    int   tick1_cnt = 0;
    int   tick3_cnt = 0;

    task automatic model_reset();
        cyc_m  = 0;
        bt_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            start_bt[i] = 0; per_m[i] = 0; os_m[i] = 1'b0; act_m[i] = 1'b0;
        end
        exp_bt = 1'b0; exp_tick = 4'h0; exp_pend = 4'h0; exp_run = 4'h0; exp_ovr = 4'h0;
    endtask

    // Advance the model across the next active edge using current inputs.
    task automatic model_step();
        bit bt_now, wr, ex;
        bt_now = (cyc_m > 0) && (cyc_m % BD == 0);
        if (bt_now) bt_cnt++;
        for (int i = 0; i < 4; i++) begin
            wr = cfg_we && (int'(cfg_ch) == i);
            ex = 1'b0;
            if (wr) begin
                per_m[i]    = int'(cfg_period);
                os_m[i]     = cfg_oneshot;
                act_m[i]    = (cfg_period != 16'd0);
                start_bt[i] = bt_cnt;
                exp_ovr[i]  = 1'b0;
            end else if (ch_stop[i]) begin
                act_m[i] = 1'b0;
            end else if (bt_now && act_m[i] && ((bt_cnt - start_bt[i]) % per_m[i] == 0)) begin
                ex = 1'b1;
                if (os_m[i]) act_m[i] = 1'b0;
            end
            if (OVR_EXP && !wr && ex && exp_pend[i] && !evt_ack[i]) exp_ovr[i] = 1'b1;
            if (ex)              exp_pend[i] = 1'b1;
            else if (evt_ack[i]) exp_pend[i] = 1'b0;
            exp_tick[i] = ex;
            exp_run[i]  = act_m[i];
        end
        exp_bt = ((cyc_m + 1) % BD == 0);
        cyc_m++;
    endtask

    // Compare DUT against the model every cycle, then step the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("reset_outputs", {base_tick, tick, evt_pending, running, overrun}, 32'h0);
        end else begin
            chk("base_tick", base_tick, exp_bt);
            chk("tick", tick, exp_tick);
            chk("evt_pending", evt_pending, exp_pend);
            chk("running", running, exp_run);
            chk("overrun", overrun, exp_ovr);
            if (tick[1]) tick1_cnt++;
            if (tick[3]) tick3_cnt++;
            model_step();
        end
    end

    // Advance to 1 time unit after edge n (bounded).
    task automatic go(input int n);
        int g;
        g = 0;
        while (cyc != n && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (cyc != n) begin
            errors++;
            $display("FAIL go: at cycle %0d, required %0d", cyc, n);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [PW-1:0] p, input logic os);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_oneshot = os;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle timebase
        go(3);  chk("bt_c3", base_tick, 1'b0);
        go(4);  chk("bt_c4", base_tick, 1'b1);
                chk("idle_outs", {tick, evt_pending, running}, 12'h000);
        go(5);  chk("bt_c5", base_tick, 1'b0);

        // ch0 P=3 periodic, ch1 P=2 one-shot, ch2 P=1 periodic never acked
        go(13); cfg(2'd0, 16'd3, 1'b0);
        go(14); cfg(2'd1, 16'd2, 1'b1);
        go(15); cfg(2'd2, 16'd1, 1'b0);
        go(16); cfg_we = 1'b0;
        go(17); chk("ch2_first_tick", tick, 4'b0100);
                chk("ch2_pend", evt_pending[2], 1'b1);
                chk("ch2_ovr_first", overrun[2], 1'b0);
        go(21); chk("ch1_ch2_tick", tick, 4'b0110);
        go(22); chk("ch1_oneshot_stopped", running[1], 1'b0);
                chk("ch2_pend_hold", evt_pending[2], 1'b1);
                chk("ch2_overrun", overrun[2], OVR_EXP);

        // Write ch3 P=2 in a base_tick cycle
        go(24); chk("bt_c24", base_tick, 1'b1);
                cfg(2'd3, 16'd2, 1'b0);
        go(25); cfg_we = 1'b0;
                chk("ch0_ch2_tick", tick, 4'b0101);
                chk("ch0_pend", evt_pending[0], 1'b1);
        go(29); chk("ch3_no_early_tick", tick, 4'b0100);
        go(33); chk("ch3_tick", tick, 4'b1100);

        // Stop ch3 mid-count; ack ch0 on the cycle of its expiry
        go(35); ch_stop = 4'b1000;
        go(36); ch_stop = 4'b0000; evt_ack = 4'b0001;
        go(37); evt_ack = 4'b0000;
                chk("ack_expiry_tick", tick, 4'b0101);
                chk("ack_expiry_pend", evt_pending[0], 1'b1);
                chk("ack_expiry_ovr", overrun[0], 1'b0);
                chk("ch3_stopped", running[3], 1'b0);
        go(40); evt_ack = 4'b0001;
        go(41); evt_ack = 4'b0000;
                chk("ch0_acked", evt_pending[0], 1'b0);

        // Long run, then asynchronous reset mid-countdown
        go(130); chk("ch1_tick_count", tick1_cnt, 1);
                 chk("ch3_tick_count", tick3_cnt, 1);
                 chk("running_before_rst", running, 4'b0101);
                 rst_n = 1'b0;
                 #1 chk("async_reset_outs", {base_tick, tick, evt_pending, running, overrun}, 17'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        go(3);  chk("post_rst_bt_c3", base_tick, 1'b0);
        go(4);  chk("post_rst_bt_c4", base_tick, 1'b1);
                chk("post_rst_running", running, 4'b0000);
        go(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
